// File: rtl/fc_pkg.sv
// Shared constants for the fc feature feeder: default sizes, FSM encodings and
// counter sizing helpers.
package fc_pkg;

   localparam int unsigned FC_DW          = 8;
   localparam int unsigned FC_NUM_INPUTS  = 4;
   localparam int unsigned FC_NUM_NEURONS = 10;
   localparam int unsigned REQS_PER_RUN   = (FC_NUM_NEURONS / 2) * FC_NUM_INPUTS;

   typedef logic [2:0] fc_state_t;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_READY = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_RUN   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // Address width for an n-entry array; never zero.
   function automatic int unsigned fc_idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width able to hold every value 0..max_val without wrapping.
   function automatic int unsigned fc_cnt_width(input int unsigned max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/fc_vec_buffer.sv
// Small register-array buffer: one synchronous write port and one combinational
// read port that returns zero for addresses past the last entry.
module fc_vec_buffer
   import fc_pkg::*;
#(
   parameter int unsigned DW    = FC_DW,
   parameter int unsigned DEPTH = FC_NUM_INPUTS,
   parameter int unsigned AW    = fc_idx_width(DEPTH)
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [AW-1:0]        waddr_i,
   input  logic signed [DW-1:0] wdata_i,
   input  logic [AW-1:0]        raddr_i,
   output logic signed [DW-1:0] rdata_o
);

   logic signed [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i && (32'(waddr_i) < DEPTH)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_o = '0;
      if (32'(raddr_i) < DEPTH) begin
         rdata_o = mem_q[raddr_i];
      end
   end

endmodule

// File: rtl/fc_feature_feeder.sv
// Host-side feeder for the FC engine: holds one feature vector, serves it element
// by element on request, and captures the engine's result stream.
module fc_feature_feeder
   import fc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = FC_DW,
   parameter int unsigned NUM_INPUTS  = FC_NUM_INPUTS,
   parameter int unsigned NUM_NEURONS = FC_NUM_NEURONS
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                load_valid,
   input  logic signed [DATA_WIDTH-1:0]        load_data,
   output logic                                load_ready,
   input  logic                                run,
   output logic                                fc_start,
   input  logic                                fc_input_req,
   output logic signed [DATA_WIDTH-1:0]        fc_feature,
   input  logic                                fc_out_valid,
   input  logic signed [DATA_WIDTH-1:0]        fc_result,
   input  logic                                fc_done,
   input  logic [$clog2(NUM_NEURONS)-1:0]      res_rd_addr,
   output logic signed [DATA_WIDTH-1:0]        res_rd_data,
   output logic                                busy,
   output logic                                done,
   output logic                                err
);

   localparam int unsigned REQS = (NUM_NEURONS / 2) * NUM_INPUTS;
   localparam int unsigned FIW  = fc_idx_width(NUM_INPUTS);
   localparam int unsigned RAW  = $clog2(NUM_NEURONS);
   localparam int unsigned RCW  = fc_cnt_width(REQS);
   localparam int unsigned NCW  = fc_cnt_width(NUM_NEURONS);

   fc_state_t                    state_q, state_d;
   logic [FIW-1:0]               load_idx_q, load_idx_d;
   logic [FIW-1:0]               feat_idx_q, feat_idx_d;
   logic [RCW-1:0]               req_cnt_q, req_cnt_d;
   logic [NCW-1:0]               res_cnt_q, res_cnt_d;
   logic signed [DATA_WIDTH-1:0] feature_q, feature_d;
   logic                         err_q, err_d;
   logic                         fc_start_q, busy_q, done_q, load_ready_q;
   logic                         vec_we, res_we;
   logic signed [DATA_WIDTH-1:0] vec_rdata;

   fc_vec_buffer #(
      .DW    (DATA_WIDTH),
      .DEPTH (NUM_INPUTS),
      .AW    (FIW)
   ) u_vec (
      .clk     (clk),
      .we_i    (vec_we),
      .waddr_i (load_idx_q),
      .wdata_i (load_data),
      .raddr_i (feat_idx_q),
      .rdata_o (vec_rdata)
   );

   fc_vec_buffer #(
      .DW    (DATA_WIDTH),
      .DEPTH (NUM_NEURONS),
      .AW    (RAW)
   ) u_res (
      .clk     (clk),
      .we_i    (res_we),
      .waddr_i (RAW'(res_cnt_q)),
      .wdata_i (fc_result),
      .raddr_i (res_rd_addr),
      .rdata_o (res_rd_data)
   );

   // Next-state, counters and buffer write enables.
   always_comb begin
      state_d    = state_q;
      load_idx_d = load_idx_q;
      feat_idx_d = feat_idx_q;
      req_cnt_d  = req_cnt_q;
      res_cnt_d  = res_cnt_q;
      feature_d  = feature_q;
      err_d      = err_q;
      vec_we     = 1'b0;
      res_we     = 1'b0;

      // Engine traffic while the engine was never started is a protocol error.
      if ((state_q != S_RUN) && (state_q != S_START) && (fc_input_req || fc_out_valid)) begin
         err_d = 1'b1;
      end

      case (state_q)
         S_IDLE, S_LOAD, S_READY: begin
            // load_idx_q is zero in IDLE and READY, so a load there restarts the vector.
            if (load_valid) begin
               vec_we = 1'b1;
               if (load_idx_q == FIW'(NUM_INPUTS - 1)) begin
                  load_idx_d = '0;
                  state_d    = S_READY;
               end else begin
                  load_idx_d = load_idx_q + FIW'(1);
                  state_d    = S_LOAD;
               end
            end else if (run && (state_q == S_READY)) begin
               state_d    = S_START;
               err_d      = 1'b0;
               feat_idx_d = '0;
               req_cnt_d  = '0;
               res_cnt_d  = '0;
            end
         end
         S_START: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (fc_input_req) begin
               feature_d  = vec_rdata;
               feat_idx_d = (feat_idx_q == FIW'(NUM_INPUTS - 1)) ? '0 : feat_idx_q + FIW'(1);
               if (req_cnt_q == RCW'(REQS)) begin
                  err_d = 1'b1;
               end else begin
                  req_cnt_d = req_cnt_q + RCW'(1);
               end
            end
            if (fc_out_valid) begin
               if (res_cnt_q < NCW'(NUM_NEURONS)) begin
                  res_we    = 1'b1;
                  res_cnt_d = res_cnt_q + NCW'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            // Check uses the _d counts so a same-cycle result is included.
            if (fc_done) begin
               if ((res_cnt_d == NCW'(NUM_NEURONS)) && (req_cnt_d == RCW'(REQS)) && !err_d) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_READY;
                  err_d   = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_READY;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counters and registered status outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         load_idx_q   <= '0;
         feat_idx_q   <= '0;
         req_cnt_q    <= '0;
         res_cnt_q    <= '0;
         feature_q    <= '0;
         err_q        <= 1'b0;
         fc_start_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         load_idx_q   <= load_idx_d;
         feat_idx_q   <= feat_idx_d;
         req_cnt_q    <= req_cnt_d;
         res_cnt_q    <= res_cnt_d;
         feature_q    <= feature_d;
         err_q        <= err_d;
         fc_start_q   <= (state_d == S_START);
         busy_q       <= (state_d == S_START) || (state_d == S_RUN);
         done_q       <= (state_d == S_DONE);
         load_ready_q <= (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_READY);
      end
   end

   assign fc_start   = fc_start_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign load_ready = load_ready_q;
   assign fc_feature = feature_q;

endmodule

// File: tb/tb_fc_feature_feeder.sv
// Directed bench for fc_feature_feeder with a behavioural FC engine and a
// scoreboard of expected features and results.
module tb_fc_feature_feeder;

   logic              clk = 1'b0;
   logic              rst;
   logic              load_valid;
   logic signed [7:0] load_data;
   logic              load_ready;
   logic              run;
   logic              fc_start;
   logic              fc_input_req;
   logic signed [7:0] fc_feature;
   logic              fc_out_valid;
   logic signed [7:0] fc_result;
   logic              fc_done;
   logic [3:0]        res_rd_addr;
   logic signed [7:0] res_rd_data;
   logic              busy;
   logic              done;
   logic              err;

   int n_checks = 0;
   int n_fails  = 0;

   int vec_m [4];
   int exp_res [10];
   int fidx;
   int feat_q [$];

   fc_feature_feeder dut (
      .clk          (clk),
      .rst          (rst),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_ready   (load_ready),
      .run          (run),
      .fc_start     (fc_start),
      .fc_input_req (fc_input_req),
      .fc_feature   (fc_feature),
      .fc_out_valid (fc_out_valid),
      .fc_result    (fc_result),
      .fc_done      (fc_done),
      .res_rd_addr  (res_rd_addr),
      .res_rd_data  (res_rd_data),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load_vec(input int a, input int b, input int c, input int d);
      int v [4];
      v = '{a, b, c, d};
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = 8'(v[i]);
         vec_m[i]   = v[i];
         tick();
      end
      load_valid = 1'b0;
   endtask

   task automatic start_run();
      int waited;
      run = 1'b1;
      tick();
      run = 1'b0;
      waited = 0;
      while (!fc_start && waited < 8) begin
         tick();
         waited++;
      end
      check("fc_start_pulse", fc_start, 1);
      check("err_cleared_on_run", err, 0);
      check("busy_in_start", busy, 1);
      tick();
      check("fc_start_one_cycle", fc_start, 0);
      fidx = 0;
   endtask

   // One engine request: feature must appear the next cycle and hold a cycle later.
   task automatic serve_req();
      int e;
      feat_q.push_back(vec_m[fidx]);
      fidx = (fidx + 1) % 4;
      fc_input_req = 1'b1;
      tick();
      fc_input_req = 1'b0;
      e = feat_q.pop_front();
      check("feature", fc_feature, e);
      tick();
      check("feature_hold", fc_feature, e);
   endtask

   task automatic fc_run(input int nres, input int rmul, input int radd);
      int v;
      bit ok;
      ok = (nres == 10);
      start_run();
      for (int r = 0; r < 20; r++) serve_req();
      for (int k = 0; k < nres; k++) begin
         v = 32'(signed'(8'(rmul * (k + 1) + radd)));
         fc_out_valid = 1'b1;
         fc_result    = 8'(v);
         if (k < 10) exp_res[k] = v;
         tick();
      end
      fc_out_valid = 1'b0;
      fc_done = 1'b1;
      tick();
      fc_done = 1'b0;
      check("done_at_end", done, ok ? 1 : 0);
      check("err_at_end", err, ok ? 0 : 1);
      check("busy_at_end", busy, 0);
      tick();
      check("done_one_cycle", done, 0);
      check("ready_after_run", load_ready, 1);
   endtask

   task automatic check_results();
      for (int a = 0; a < 10; a++) begin
         res_rd_addr = 4'(a);
         #1;
         check($sformatf("result[%0d]", a), res_rd_data, exp_res[a]);
      end
      res_rd_addr = 4'd12;
      #1;
      check("result_out_of_range", res_rd_data, 0);
   endtask

   initial begin
      rst = 1'b1;
      load_valid = 1'b0; load_data = '0; run = 1'b0;
      fc_input_req = 1'b0; fc_out_valid = 1'b0; fc_result = '0; fc_done = 1'b0;
      res_rd_addr = '0;
      fidx = 0;
      tick(); tick();
      rst = 1'b0;
      check("rst_fc_start", fc_start, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      check("rst_feature", fc_feature, 0);
      check("rst_load_ready", load_ready, 1);

      // 1: basic load and run
      load_vec(3, 0, -2, 5);
      check("load_ready_in_ready", load_ready, 1);
      fc_run(10, 1, 0);
      check_results();

      // 2: rerun without reload, new results
      fc_run(10, -3, 2);
      check_results();

      // 3: short result stream then a clean rerun
      fc_run(8, 5, 0);
      check_results();
      fc_run(10, 2, -7);
      check_results();

      // 4: stray request while READY
      fc_input_req = 1'b1;
      tick();
      fc_input_req = 1'b0;
      check("stray_req_err", err, 1);
      check("stray_req_feature", fc_feature, 5);
      check("stray_req_state", load_ready, 1);
      check("stray_req_busy", busy, 0);

      // 5: load beats run in the same cycle
      load_valid = 1'b1; load_data = 8'sd7; run = 1'b1;
      vec_m[0] = 7;
      tick();
      load_valid = 1'b0; run = 1'b0;
      check("load_run_no_start", fc_start, 0);
      check("load_run_not_busy", busy, 0);
      check("load_run_load_ready", load_ready, 1);
      check("load_run_err_kept", err, 1);
      for (int i = 1; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = 8'(i * 3 - 8);
         vec_m[i]   = i * 3 - 8;
         tick();
      end
      load_valid = 1'b0;
      fc_run(10, 4, -20);
      check_results();

      // 6: reset mid-run, then reload and rerun
      start_run();
      for (int r = 0; r < 7; r++) serve_req();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      feat_q.delete();
      check("abort_fc_start", fc_start, 0);
      check("abort_done", done, 0);
      check("abort_err", err, 0);
      check("abort_busy", busy, 0);
      check("abort_feature", fc_feature, 0);
      check("abort_load_ready", load_ready, 1);
      load_vec(1, -1, 2, -2);
      fc_run(10, -1, 0);
      check_results();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "bench did not finish");
   end

endmodule
